// File: rtl/canvas_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : canvas_pkg
//  Description : Shared canvas geometry, types and (x,y) helpers for the
//                canvas arbiter slice.
//  Revision    : 1.0 - initial release
// ============================================================================
package canvas_pkg;

  localparam int WIDTH  = 160;
  localparam int HEIGHT = 120;
  localparam int CBIT   = 11;
  localparam int AW     = 15;
  localparam int PIXELS = WIDTH * HEIGHT;
  localparam int XW     = 8;
  localparam int YW     = 7;

  typedef logic [CBIT:0] colour_t;
  typedef logic [AW-1:0] addr_t;
  typedef logic [XW-1:0] xcoord_t;
  typedef logic [YW-1:0] ycoord_t;

  typedef enum logic [0:0] {
    ST_ARB   = 1'b0,
    ST_CLEAR = 1'b1
  } arb_state_t;

  // y*160 + x as two shifts and adds; fits AW even for out-of-range inputs
  function automatic addr_t xy_to_addr(input xcoord_t x, input ycoord_t y);
    addr_t yw;
    yw = addr_t'(y);
    return (yw << 7) + (yw << 5) + addr_t'(x);
  endfunction

  function automatic logic in_range(input xcoord_t x, input ycoord_t y);
    return (int'(x) < WIDTH) && (int'(y) < HEIGHT);
  endfunction

endpackage
`default_nettype wire

// File: rtl/canvas_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : canvas_arbiter_if
//  Description : Bundle of requester, clear, canvas RAM and VGA plot signals
//                around the canvas arbiter. slave = arbiter side,
//                master = surrounding system side.
//  Revision    : 1.0 - initial release
// ============================================================================
interface canvas_arbiter_if;
  import canvas_pkg::*;

  logic    req0_valid, req0_ready, req0_we;
  xcoord_t req0_x;
  ycoord_t req0_y;
  colour_t req0_wdata;
  logic    req1_valid, req1_ready, req1_we;
  xcoord_t req1_x;
  ycoord_t req1_y;
  colour_t req1_wdata;

  logic    rsp0_valid, rsp1_valid;
  colour_t rsp0_rdata, rsp1_rdata;

  logic    clear_start;
  colour_t clear_colour;
  logic    clear_busy;

  addr_t   mem_addr;
  colour_t mem_data;
  logic    mem_wren;
  colour_t mem_q;

  xcoord_t vga_x;
  ycoord_t vga_y;
  colour_t vga_colour;
  logic    vga_plot;

  modport slave (
    input  req0_valid, req0_we, req0_x, req0_y, req0_wdata,
    input  req1_valid, req1_we, req1_x, req1_y, req1_wdata,
    output req0_ready, req1_ready,
    output rsp0_valid, rsp0_rdata, rsp1_valid, rsp1_rdata,
    input  clear_start, clear_colour,
    output clear_busy,
    output mem_addr, mem_data, mem_wren,
    input  mem_q,
    output vga_x, vga_y, vga_colour, vga_plot
  );

  modport master (
    output req0_valid, req0_we, req0_x, req0_y, req0_wdata,
    output req1_valid, req1_we, req1_x, req1_y, req1_wdata,
    input  req0_ready, req1_ready,
    input  rsp0_valid, rsp0_rdata, rsp1_valid, rsp1_rdata,
    output clear_start, clear_colour,
    input  clear_busy,
    input  mem_addr, mem_data, mem_wren,
    output mem_q,
    input  vga_x, vga_y, vga_colour, vga_plot
  );

endinterface
`default_nettype wire

// File: rtl/canvas_addr_gen.sv
`default_nettype none
// ============================================================================
//  Module      : canvas_addr_gen
//  Description : Registered (x,y) -> canvas address conversion with range
//                check. Out-of-range writes never raise the write enable;
//                out-of-range reads are flagged so their data can be zeroed.
//  Revision    : 1.0 - initial release
// ============================================================================
module canvas_addr_gen
  import canvas_pkg::*;
(
  input  logic    clk_i,
  input  logic    rst_i,
  input  logic    en_i,
  input  logic    we_i,
  input  xcoord_t x_i,
  input  ycoord_t y_i,
  input  colour_t data_i,
  output addr_t   addr_o,
  output colour_t data_o,
  output logic    wren_o,
  output logic    rd_ok_o
);

  addr_t   addr_q, addr_d;
  colour_t data_q;
  logic    wren_q, rd_ok_q;
  logic    hit_d;

  // address and range check of the request presented this cycle
  always_comb begin
    addr_d = xy_to_addr(x_i, y_i);
    hit_d  = in_range(x_i, y_i);
  end

  // register address/data; enables only for in-range accesses
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      addr_q  <= '0;
      data_q  <= '0;
      wren_q  <= 1'b0;
      rd_ok_q <= 1'b0;
    end else begin
      wren_q  <= en_i && we_i && hit_d;
      rd_ok_q <= en_i && !we_i && hit_d;
      if (en_i) addr_q <= addr_d;
      if (en_i && we_i) data_q <= data_i;
    end
  end

  assign addr_o  = addr_q;
  assign data_o  = data_q;
  assign wren_o  = wren_q;
  assign rd_ok_o = rd_ok_q;

endmodule
`default_nettype wire

// File: rtl/canvas_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : canvas_arbiter
//  Description : Shares the single-port canvas RAM between the game FSM
//                (port 0) and the blitter (port 1) with round-robin on
//                contention, runs the full-canvas clear sweep and returns
//                read data two cycles after acceptance.
//                Optional macro CANVAS_ARB_PLOT_EN mirrors every committed
//                write onto the vga_* plot outputs; otherwise they read 0.
//  Revision    : 1.0 - initial release
// ============================================================================
module canvas_arbiter
  import canvas_pkg::*;
(
  input  logic            clk_i,
  input  logic            rst_i,
  canvas_arbiter_if.slave bus
);

  arb_state_t state_q;
  logic       prio_q;
  logic       busy_q;
  colour_t    clr_colour_q;
  xcoord_t    clr_x_q;
  ycoord_t    clr_y_q;

  logic       gnt0, gnt1;
  logic       ag_en, ag_we;
  xcoord_t    ag_x;
  ycoord_t    ag_y;
  colour_t    ag_data;
  logic       ag_rd_ok;
  logic       sweep_last;

  logic       rd_v1_q, rd_tag1_q;
  logic       rd_v2_q, rd_tag2_q, rd_ok2_q;
  colour_t    rd0_hold_q, rd1_hold_q;
  colour_t    rd_now;

  // grant: clear_start blocks both ports; contention resolved by the pointer
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (state_q == ST_ARB && !bus.clear_start) begin
      if (bus.req0_valid && (!bus.req1_valid || !prio_q)) gnt0 = 1'b1;
      else if (bus.req1_valid)                           gnt1 = 1'b1;
    end
  end

  // the sweep and the granted port share one address generator
  always_comb begin
    ag_en   = 1'b0;
    ag_we   = 1'b0;
    ag_x    = '0;
    ag_y    = '0;
    ag_data = '0;
    if (state_q == ST_CLEAR) begin
      ag_en   = 1'b1;
      ag_we   = 1'b1;
      ag_x    = clr_x_q;
      ag_y    = clr_y_q;
      ag_data = clr_colour_q;
    end else if (gnt1) begin
      ag_en   = 1'b1;
      ag_we   = bus.req1_we;
      ag_x    = bus.req1_x;
      ag_y    = bus.req1_y;
      ag_data = bus.req1_wdata;
    end else if (gnt0) begin
      ag_en   = 1'b1;
      ag_we   = bus.req0_we;
      ag_x    = bus.req0_x;
      ag_y    = bus.req0_y;
      ag_data = bus.req0_wdata;
    end
  end

  assign sweep_last = (clr_x_q == xcoord_t'(WIDTH - 1)) &&
                      (clr_y_q == ycoord_t'(HEIGHT - 1));

  // control FSM: arbitration pointer, clear latch and sweep counters
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= ST_ARB;
      prio_q       <= 1'b0;
      busy_q       <= 1'b0;
      clr_colour_q <= '0;
      clr_x_q      <= '0;
      clr_y_q      <= '0;
    end else begin
      case (state_q)
        ST_ARB: begin
          if (bus.clear_start) begin
            state_q      <= ST_CLEAR;
            busy_q       <= 1'b1;
            clr_colour_q <= bus.clear_colour;
            clr_x_q      <= '0;
            clr_y_q      <= '0;
          end else if (bus.req0_valid && bus.req1_valid) begin
            prio_q <= ~prio_q;
          end
        end
        ST_CLEAR: begin
          if (sweep_last) begin
            state_q <= ST_ARB;
            busy_q  <= 1'b0;
          end else if (clr_x_q == xcoord_t'(WIDTH - 1)) begin
            clr_x_q <= '0;
            clr_y_q <= clr_y_q + 1'b1;
          end else begin
            clr_x_q <= clr_x_q + 1'b1;
          end
        end
        default: state_q <= ST_ARB;
      endcase
    end
  end

  canvas_addr_gen u_addr_gen (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .en_i    (ag_en),
    .we_i    (ag_we),
    .x_i     (ag_x),
    .y_i     (ag_y),
    .data_i  (ag_data),
    .addr_o  (bus.mem_addr),
    .data_o  (bus.mem_data),
    .wren_o  (bus.mem_wren),
    .rd_ok_o (ag_rd_ok)
  );

  // two-stage read tag pipeline lining up with the RAM read latency
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_v1_q   <= 1'b0;
      rd_tag1_q <= 1'b0;
      rd_v2_q   <= 1'b0;
      rd_tag2_q <= 1'b0;
      rd_ok2_q  <= 1'b0;
    end else begin
      rd_v1_q   <= (gnt0 || gnt1) && !ag_we;
      rd_tag1_q <= gnt1;
      rd_v2_q   <= rd_v1_q;
      rd_tag2_q <= rd_tag1_q;
      rd_ok2_q  <= ag_rd_ok;
    end
  end

  assign rd_now         = rd_ok2_q ? bus.mem_q : '0;
  assign bus.rsp0_valid = rd_v2_q && !rd_tag2_q;
  assign bus.rsp1_valid = rd_v2_q && rd_tag2_q;
  assign bus.rsp0_rdata = bus.rsp0_valid ? rd_now : rd0_hold_q;
  assign bus.rsp1_rdata = bus.rsp1_valid ? rd_now : rd1_hold_q;

  // keep each port's last response visible until the next one
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd0_hold_q <= '0;
      rd1_hold_q <= '0;
    end else begin
      if (bus.rsp0_valid) rd0_hold_q <= rd_now;
      if (bus.rsp1_valid) rd1_hold_q <= rd_now;
    end
  end

  assign bus.req0_ready = gnt0;
  assign bus.req1_ready = gnt1;
  assign bus.clear_busy = busy_q;

`ifdef CANVAS_ARB_PLOT_EN
  logic    plot_q;
  xcoord_t plot_x_q;
  ycoord_t plot_y_q;
  colour_t plot_c_q;
  logic    commit;

  assign commit = ag_en && ag_we && in_range(ag_x, ag_y);

  // mirror each committed canvas write onto the VGA plot port
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      plot_q   <= 1'b0;
      plot_x_q <= '0;
      plot_y_q <= '0;
      plot_c_q <= '0;
    end else begin
      plot_q <= commit;
      if (commit) begin
        plot_x_q <= ag_x;
        plot_y_q <= ag_y;
        plot_c_q <= ag_data;
      end
    end
  end

  assign bus.vga_plot   = plot_q;
  assign bus.vga_x      = plot_x_q;
  assign bus.vga_y      = plot_y_q;
  assign bus.vga_colour = plot_c_q;
`else
  assign bus.vga_plot   = 1'b0;
  assign bus.vga_x      = '0;
  assign bus.vga_y      = '0;
  assign bus.vga_colour = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_canvas_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_canvas_arbiter
//  Description : Self-checking bench for canvas_arbiter with a canvas-level
//                reference model, a registered-read RAM model and directed
//                scenarios with literal expectations.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_canvas_arbiter;
  import canvas_pkg::*;

`ifdef CANVAS_ARB_PLOT_EN
  localparam bit PLOT = 1'b1;
`else
  localparam bit PLOT = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  canvas_arbiter_if bus ();

  canvas_arbiter dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- canvas RAM: registered read, one cycle latency --------
  logic [CBIT:0] ram [0:32767];
  initial begin
    for (int i = 0; i < 32768; i++) ram[i] <= '0;
    ram[0] <= 12'h111;
    ram[1] <= 12'h222;
    bus.mem_q <= '0;
    forever begin
      @(posedge clk);
      if (bus.mem_wren) ram[bus.mem_addr] <= bus.mem_data;
      bus.mem_q <= ram[bus.mem_addr];
    end
  end

  // ---------------- reference model + per-cycle compare --------------------
  typedef struct { int cyc; int port; logic [CBIT:0] data; } rsp_t;
  rsp_t          rq[$];
  logic [CBIT:0] pix [0:HEIGHT-1][0:WIDTH-1];
  logic [CBIT:0] last_rd [2];
  bit            m_clear, m_prio;
  int            m_sweep;
  logic [CBIT:0] m_col;
  bit            e_wren, e_rd, e_plot, e_busy;
  int            e_addr, e_x, e_y;
  logic [CBIT:0] e_data;
  int            cyc = 0;

  initial begin
    for (int y = 0; y < HEIGHT; y++)
      for (int x = 0; x < WIDTH; x++) pix[y][x] = '0;
    pix[0][0] = 12'h111;
    pix[0][1] = 12'h222;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        chk("rst_mem_wren", bus.mem_wren, 0);
        chk("rst_mem_addr", bus.mem_addr, 0);
        chk("rst_busy", bus.clear_busy, 0);
        chk("rst_plot", bus.vga_plot, 0);
        chk("rst_rsp0", bus.rsp0_valid, 0);
        chk("rst_rsp1", bus.rsp1_valid, 0);
        m_clear = 0; m_prio = 0; m_sweep = 0; rq.delete();
        last_rd[0] = '0; last_rd[1] = '0;
        e_wren = 0; e_rd = 0; e_plot = 0; e_busy = 0;
      end else begin
        bit er0, er1, v0, v1, we, ok;
        int p, x, y;
        logic [CBIT:0] wd;
        v0  = bus.req0_valid;
        v1  = bus.req1_valid;
        er0 = !m_clear && !bus.clear_start && v0 && (!v1 || !m_prio);
        er1 = !m_clear && !bus.clear_start && v1 && !er0;
        chk("ready0", bus.req0_ready, er0);
        chk("ready1", bus.req1_ready, er1);
        chk("mem_wren", bus.mem_wren, e_wren);
        if (e_wren || e_rd) chk("mem_addr", bus.mem_addr, e_addr);
        if (e_wren) chk("mem_data", bus.mem_data, e_data);
        chk("vga_plot", bus.vga_plot, e_plot);
        if (e_plot) begin
          chk("vga_x", bus.vga_x, e_x);
          chk("vga_y", bus.vga_y, e_y);
          chk("vga_colour", bus.vga_colour, e_data);
        end
        chk("clear_busy", bus.clear_busy, e_busy);
        for (int q = 0; q < 2; q++) begin
          bit due;
          logic [CBIT:0] act_d;
          due = (rq.size() > 0) && (rq[0].cyc == cyc) && (rq[0].port == q);
          act_d = (q == 0) ? bus.rsp0_rdata : bus.rsp1_rdata;
          chk(q == 0 ? "rsp0_valid" : "rsp1_valid",
              q == 0 ? bus.rsp0_valid : bus.rsp1_valid, due);
          if (due) begin
            last_rd[q] = rq[0].data;
            void'(rq.pop_front());
          end
          chk(q == 0 ? "rsp0_rdata" : "rsp1_rdata", act_d, last_rd[q]);
        end
        // predict what the next cycle shows
        e_wren = 0; e_rd = 0; e_plot = 0;
        if (m_clear) begin
          e_wren = 1; e_addr = m_sweep; e_data = m_col; e_plot = PLOT;
          e_x = m_sweep % WIDTH; e_y = m_sweep / WIDTH;
          pix[e_y][e_x] = m_col;
          m_sweep++;
          if (m_sweep == PIXELS) m_clear = 0;
        end else if (bus.clear_start) begin
          m_clear = 1; m_sweep = 0; m_col = bus.clear_colour;
        end else if (er0 || er1) begin
          p  = er1 ? 1 : 0;
          we = p ? bus.req1_we : bus.req0_we;
          x  = p ? int'(bus.req1_x) : int'(bus.req0_x);
          y  = p ? int'(bus.req1_y) : int'(bus.req0_y);
          wd = p ? bus.req1_wdata : bus.req0_wdata;
          if (v0 && v1) m_prio = !m_prio;
          ok = (x < WIDTH) && (y < HEIGHT);
          e_addr = y * WIDTH + x;
          if (we) begin
            e_wren = ok; e_plot = ok && PLOT; e_data = wd; e_x = x; e_y = y;
            if (ok) pix[y][x] = wd;
          end else begin
            e_rd = ok;
            rq.push_back('{cyc + 2, p, ok ? pix[y][x] : '0});
          end
        end
        e_busy = m_clear;
      end
    end
  end

  // ---------------- directed stimulus ---------------------------------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input int p, input bit we, input int x, input int y, input int d);
    if (p == 0) begin
      bus.req0_valid = 1'b1; bus.req0_we = we; bus.req0_x = 8'(x);
      bus.req0_y = 7'(y); bus.req0_wdata = 12'(d);
    end else begin
      bus.req1_valid = 1'b1; bus.req1_we = we; bus.req1_x = 8'(x);
      bus.req1_y = 7'(y); bus.req1_wdata = 12'(d);
    end
  endtask

  task automatic idle();
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
  endtask

  initial begin
    bit exp_alt [4];
    int wr, lim;
    bit done, rdy_seen;
    exp_alt = '{1'b1, 1'b0, 1'b1, 1'b0};
    bus.req0_valid = 0; bus.req0_we = 0; bus.req0_x = 0; bus.req0_y = 0; bus.req0_wdata = 0;
    bus.req1_valid = 0; bus.req1_we = 0; bus.req1_x = 0; bus.req1_y = 0; bus.req1_wdata = 0;
    bus.clear_start = 0; bus.clear_colour = 0;
    repeat (3) step();
    rst = 1'b0;
    step();

    // write then read back the same pixel from the other port
    drv(0, 1, 10, 5, 12'hF00);
    #1 chk("w0_ready", bus.req0_ready, 1);
    step();
    chk("w0_addr", bus.mem_addr, 810);
    chk("w0_wren", bus.mem_wren, 1);
    chk("w0_data", bus.mem_data, 12'hF00);
    chk("w0_plot", bus.vga_plot, PLOT);
    idle();
    drv(1, 0, 10, 5, 0);
    #1 chk("r1_ready", bus.req1_ready, 1);
    step();
    idle();
    chk("r1_wren", bus.mem_wren, 0);
    chk("r1_addr", bus.mem_addr, 810);
    step();
    chk("r1_valid", bus.rsp1_valid, 1);
    chk("r1_data", bus.rsp1_rdata, 12'hF00);
    step();

    // contention: grants alternate starting at port 0
    for (int i = 0; i < 4; i++) begin
      drv(0, 1, 20 + i, 7, 12'h0A0);
      drv(1, 1, 40 + i, 7, 12'h0B0);
      #1;
      chk("alt_ready0", bus.req0_ready, exp_alt[i]);
      chk("alt_ready1", bus.req1_ready, !exp_alt[i]);
      step();
    end
    idle();
    step();

    // range boundaries
    drv(0, 1, 159, 119, 12'h123);
    step();
    chk("edge_addr", bus.mem_addr, 19199);
    chk("edge_wren", bus.mem_wren, 1);
    drv(0, 1, 160, 0, 12'h456);
    step();
    chk("oor_wren", bus.mem_wren, 0);
    chk("oor_plot", bus.vga_plot, 0);
    drv(0, 0, 0, 120, 0);
    step();
    idle();
    step();
    chk("oor_rsp_valid", bus.rsp0_valid, 1);
    chk("oor_rsp_data", bus.rsp0_rdata, 0);
    step();

    // back-to-back reads on alternating ports
    drv(0, 0, 0, 0, 0);
    step();
    idle();
    drv(1, 0, 1, 0, 0);
    step();
    idle();
    chk("b2b_rsp0_valid", bus.rsp0_valid, 1);
    chk("b2b_rsp0_data", bus.rsp0_rdata, 12'h111);
    step();
    chk("b2b_rsp1_valid", bus.rsp1_valid, 1);
    chk("b2b_rsp1_data", bus.rsp1_rdata, 12'h222);
    chk("b2b_rsp0_quiet", bus.rsp0_valid, 0);
    step();

    // full clear with port 0 waiting
    bus.clear_colour = 12'h00F;
    bus.clear_start  = 1'b1;
    drv(0, 1, 2, 2, 12'hABC);
    #1 chk("clr_start_ready0", bus.req0_ready, 0);
    step();
    bus.clear_start = 1'b0;
    wr = 0; done = 0; rdy_seen = 0;
    for (int i = 0; i < 20005; i++) begin
      if (bus.mem_wren) wr++;
      if (!bus.clear_busy) begin
        done = 1;
        break;
      end
      if (bus.req0_ready) rdy_seen = 1;
      step();
    end
    chk("clr_finished", done, 1);
    chk("clr_write_count", wr, 19200);
    chk("clr_ready_seen", rdy_seen, 0);
    chk("clr_then_ready0", bus.req0_ready, 1);
    step();
    idle();
    chk("clr_then_wren", bus.mem_wren, 1);
    chk("clr_then_addr", bus.mem_addr, 322);
    step();

    // reset in the middle of a sweep
    bus.clear_colour = 12'h5A5;
    bus.clear_start  = 1'b1;
    step();
    bus.clear_start = 1'b0;
    done = 0;
    lim  = 0;
    while (!done && lim < 6000) begin
      if (bus.mem_wren && bus.mem_addr == 15'd5000) done = 1;
      else begin
        step();
        lim++;
      end
    end
    chk("sweep_reached_5000", done, 1);
    rst = 1'b1;
    step();
    chk("mid_rst_addr", bus.mem_addr, 0);
    chk("mid_rst_data", bus.mem_data, 0);
    chk("mid_rst_wren", bus.mem_wren, 0);
    chk("mid_rst_busy", bus.clear_busy, 0);
    chk("mid_rst_vga_x", bus.vga_x, 0);
    chk("mid_rst_vga_colour", bus.vga_colour, 0);
    rst = 1'b0;
    drv(0, 1, 3, 3, 12'h777);
    #1 chk("post_rst_ready0", bus.req0_ready, 1);
    step();
    idle();
    chk("post_rst_busy", bus.clear_busy, 0);
    chk("post_rst_wren", bus.mem_wren, 1);
    chk("post_rst_addr", bus.mem_addr, 483);
    repeat (4) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
